// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0100_0000;
    localparam int unsigned PC_STEP          = 32'd4;

    // Default queue entry for a 32-bit address / 32-bit instruction build.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    // Saturating 32-bit add used by the performance counters.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/fetch_prefetch_buffer_if.sv
// Memory-side and decode-side signals of the fetch stage, bundled.
// master = the fetch stage, slave = memory + decode environment.
interface fetch_prefetch_buffer_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
);
    logic [AWIDTH-1:0] mem_addr_o;
    logic              mem_read_en_o;
    logic [DWIDTH-1:0] mem_data_i;
    logic              redirect_i;
    logic [AWIDTH-1:0] redirect_pc_i;
    logic              insn_valid_o;
    logic              insn_ready_i;
    logic [DWIDTH-1:0] insn_o;
    logic [AWIDTH-1:0] pc_o;

    modport master (
        output mem_addr_o, mem_read_en_o, insn_valid_o, insn_o, pc_o,
        input  mem_data_i, redirect_i, redirect_pc_i, insn_ready_i
    );

    modport slave (
        input  mem_addr_o, mem_read_en_o, insn_valid_o, insn_o, pc_o,
        output mem_data_i, redirect_i, redirect_pc_i, insn_ready_i
    );
endinterface

// File: rtl/fetch_sync_fifo.sv
// Power-of-two synchronous FIFO with flush; push is accepted while full
// only when a pop happens in the same cycle. Flush beats push.
module fetch_sync_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output entry_t                 head_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_s, do_push_s, do_pop_s;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        full_s    = (count_q == CW'(DEPTH));
        do_pop_s  = pop_i && (count_q != '0);
        do_push_s = push_i && (!full_s || do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch stage with prefetch queue. Issues sequential PCs to a
// fixed-latency memory under a credit rule (queued + in flight < DEPTH),
// tracks requests in a MEM_LAT-deep shift register and queues {pc, insn}
// for decode. Redirect and reset flush both queue and in-flight work.
// Optional build macro FETCH_PERF_EN adds saturating issue/stall/flush counters.
module fetch_prefetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned       AWIDTH   = 32,
    parameter int unsigned       DWIDTH   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       MEM_LAT  = 1,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                    clk,
    input  logic                    rst,
    fetch_prefetch_buffer_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]             perf_issue_o,
    output logic [31:0]             perf_stall_o,
    output logic [31:0]             perf_flush_o
`endif
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned IW = $clog2(MEM_LAT + 1);
    localparam int unsigned SW = $clog2(DEPTH + MEM_LAT + 1);

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] insn;
    } entry_t;

    logic [AWIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [MEM_LAT-1:0] lat_vld_q, lat_vld_d;
    logic [AWIDTH-1:0]  lat_pc_q [MEM_LAT];
    logic [AWIDTH-1:0]  lat_pc_d [MEM_LAT];

    logic [IW-1:0] inflight_s;
    logic [SW-1:0] occ_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_empty_s;
    entry_t        fifo_head_s;
    entry_t        push_data_s;
    logic          credit_s, issue_s, insn_valid_s, pop_s, push_s;
    logic          unused_redirect_lsb_s;

    assign unused_redirect_lsb_s = ^bus.redirect_pc_i[1:0];

    // Credit: everything queued or still in flight must fit in the queue.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight_s = inflight_s + IW'(lat_vld_q[i]);
        end
        occ_s        = SW'(fifo_count_s) + SW'(inflight_s);
        credit_s     = (occ_s < SW'(DEPTH));
        issue_s      = rst && !bus.redirect_i && credit_s;
        insn_valid_s = rst && !bus.redirect_i && !fifo_empty_s;
        pop_s        = insn_valid_s && bus.insn_ready_i;
    end

    // Next fetch PC: redirect wins over sequential advance.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_i) begin
            fetch_pc_d = {bus.redirect_pc_i[AWIDTH-1:2], 2'b00};
        end else if (issue_s) begin
            fetch_pc_d = fetch_pc_q + AWIDTH'(PC_STEP);
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    // In-flight tracker: one {valid, pc} stage per cycle of memory latency.
    always_comb begin
        lat_vld_d    = lat_vld_q;
        lat_pc_d     = lat_pc_q;
        lat_pc_d[0]  = fetch_pc_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            lat_pc_d[i] = lat_pc_q[i-1];
        end
        if (bus.redirect_i) begin
            lat_vld_d = '0;
        end else begin
            lat_vld_d[0] = issue_s;
            for (int i = 1; i < MEM_LAT; i++) begin
                lat_vld_d[i] = lat_vld_q[i-1];
            end
        end
    end

    // PC and tracker registers; reset discards every outstanding request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            lat_vld_q  <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                lat_pc_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            lat_vld_q  <= lat_vld_d;
            lat_pc_q   <= lat_pc_d;
        end
    end

    assign push_s           = lat_vld_q[MEM_LAT-1];
    assign push_data_s.pc   = lat_pc_q[MEM_LAT-1];
    assign push_data_s.insn = bus.mem_data_i;

    fetch_sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .flush_i     (bus.redirect_i),
        .head_o      (fifo_head_s),
        .empty_o     (fifo_empty_s),
        .count_o     (fifo_count_s)
    );

    assign bus.mem_read_en_o = issue_s;
    assign bus.mem_addr_o    = fetch_pc_q;
    assign bus.insn_valid_o  = insn_valid_s;
    assign bus.insn_o        = (rst && !fifo_empty_s) ? fifo_head_s.insn : '0;
    assign bus.pc_o          = (rst && !fifo_empty_s) ? fifo_head_s.pc : '0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_issue_q, perf_issue_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Counter updates; a redirect discards everything queued or in flight.
    always_comb begin
        perf_issue_d = sat_add32(perf_issue_q, {31'd0, issue_s});
        perf_stall_d = sat_add32(perf_stall_q, {31'd0, rst && !bus.redirect_i && !credit_s});
        if (rst && bus.redirect_i) begin
            perf_flush_d = sat_add32(perf_flush_q, 32'(occ_s));
        end else begin
            perf_flush_d = perf_flush_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_issue_q <= 32'd0;
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_issue_o = perf_issue_q;
    assign perf_stall_o = perf_stall_q;
    assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer: a per-cycle vector table on a
// DEPTH=4/MEM_LAT=1 instance, plus hand sequences on a MEM_LAT=2/DEPTH=8
// instance (redirect flush) and a MEM_LAT=3 instance (mid-flight reset).
module tb_fetch_prefetch_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] B = 32'h0100_0000;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- instances ----------------
    logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
    fetch_prefetch_buffer_if #(.AWIDTH(32), .DWIDTH(32)) if_a ();
    fetch_prefetch_buffer_if #(.AWIDTH(32), .DWIDTH(32)) if_b ();
    fetch_prefetch_buffer_if #(.AWIDTH(32), .DWIDTH(32)) if_c ();
`ifdef FETCH_PERF_EN
    logic [31:0] pi_a, ps_a, pf_a, pi_b, ps_b, pf_b, pi_c, ps_c, pf_c;
`endif

    fetch_prefetch_buffer #(.DEPTH(4), .MEM_LAT(1)) dut_a (
        .clk(clk), .rst(rst_a), .bus(if_a)
`ifdef FETCH_PERF_EN
        , .perf_issue_o(pi_a), .perf_stall_o(ps_a), .perf_flush_o(pf_a)
`endif
    );
    fetch_prefetch_buffer #(.DEPTH(8), .MEM_LAT(2)) dut_b (
        .clk(clk), .rst(rst_b), .bus(if_b)
`ifdef FETCH_PERF_EN
        , .perf_issue_o(pi_b), .perf_stall_o(ps_b), .perf_flush_o(pf_b)
`endif
    );
    fetch_prefetch_buffer #(.DEPTH(4), .MEM_LAT(3)) dut_c (
        .clk(clk), .rst(rst_c), .bus(if_c)
`ifdef FETCH_PERF_EN
        , .perf_issue_o(pi_c), .perf_stall_o(ps_c), .perf_flush_o(pf_c)
`endif
    );

    // ---------------- fixed-latency memory models (not reset) ----------------
    logic [2:0]  mv_a = 3'b0, mv_b = 3'b0, mv_c = 3'b0;
    logic [31:0] ma_a [3], ma_b [3], ma_c [3];

    always @(posedge clk) begin
        mv_a <= {mv_a[1:0], if_a.mem_read_en_o};
        mv_b <= {mv_b[1:0], if_b.mem_read_en_o};
        mv_c <= {mv_c[1:0], if_c.mem_read_en_o};
        ma_a[0] <= if_a.mem_addr_o; ma_a[1] <= ma_a[0]; ma_a[2] <= ma_a[1];
        ma_b[0] <= if_b.mem_addr_o; ma_b[1] <= ma_b[0]; ma_b[2] <= ma_b[1];
        ma_c[0] <= if_c.mem_addr_o; ma_c[1] <= ma_c[0]; ma_c[2] <= ma_c[1];
    end
    assign if_a.mem_data_i = mv_a[0] ? insn_of(ma_a[0]) : 32'hBAD0_BAD0;
    assign if_b.mem_data_i = mv_b[1] ? insn_of(ma_b[1]) : 32'hBAD0_BAD0;
    assign if_c.mem_data_i = mv_c[2] ? insn_of(ma_c[2]) : 32'hBAD0_BAD0;

    // ---------------- vector table for instance A ----------------
    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic        exp_vld;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy,
                     input logic en, input logic [31:0] addr, input logic vld, input logic [31:0] pc);
        vec_t e;
        e.rst = r; e.redir = rd; e.rpc = rpc; e.rdy = rdy;
        e.exp_en = en; e.exp_addr = addr; e.exp_vld = vld; e.exp_pc = pc;
        vq.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if_a.redirect_i = 1'b0; if_a.redirect_pc_i = 32'd0; if_a.insn_ready_i = 1'b0;
        if_b.redirect_i = 1'b0; if_b.redirect_pc_i = 32'd0; if_b.insn_ready_i = 1'b0;
        if_c.redirect_i = 1'b0; if_c.redirect_pc_i = 32'd0; if_c.insn_ready_i = 1'b0;

        //  rst   redir  rpc            rdy   en    addr            vld   pc
        v(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0);          // 0 reset
        v(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0);          // 1 reset
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, B,             1'b0, 32'h0);          // 2
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, B + 32'd4,     1'b0, 32'h0);          // 3
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, B + 32'd8,     1'b1, B);              // 4 first valid
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, B + 32'd12,    1'b1, B + 32'd4);      // 5
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, B + 32'd16,    1'b1, B + 32'd8);      // 6
        v(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0);          // 7 mid reset
        v(1'b1, 1'b0, 32'h0,         1'b0, 1'b1, B,             1'b0, 32'h0);          // 8 ready low
        v(1'b1, 1'b0, 32'h0,         1'b0, 1'b1, B + 32'd4,     1'b0, 32'h0);          // 9
        v(1'b1, 1'b0, 32'h0,         1'b0, 1'b1, B + 32'd8,     1'b1, B);              // 10
        v(1'b1, 1'b0, 32'h0,         1'b0, 1'b1, B + 32'd12,    1'b1, B);              // 11 4th issue
        v(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, B);              // 12 credit out
        v(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, B);              // 13 full
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, B);              // 14 ready pulse
        v(1'b1, 1'b0, 32'h0,         1'b0, 1'b1, B + 32'd16,    1'b1, B + 32'd4);      // 15 one issue
        v(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, B + 32'd4);      // 16
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, B + 32'd4);      // 17 drain full
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, B + 32'd20,    1'b1, B + 32'd8);      // 18
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, B + 32'd24,    1'b1, B + 32'd12);     // 19 push+pop
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, B + 32'd28,    1'b1, B + 32'd16);     // 20
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, B + 32'd32,    1'b1, B + 32'd20);     // 21
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, B + 32'd36,    1'b1, B + 32'd24);     // 22
        v(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);          // 23 redirect
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);          // 24
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0);          // 25 wrap
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC);  // 26
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000);  // 27
        v(1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);          // 28 redirect
        v(1'b1, 1'b1, 32'h0000_2002, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);          // 29 last wins
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_2000, 1'b0, 32'h0);          // 30
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_2004, 1'b0, 32'h0);          // 31
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_2008, 1'b1, 32'h0000_2000);  // 32
        v(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_200C, 1'b1, 32'h0000_2004);  // 33

        @(posedge clk); #1;

        for (int i = 0; i < vq.size(); i++) begin
            rst_a              = vq[i].rst;
            if_a.redirect_i    = vq[i].redir;
            if_a.redirect_pc_i = vq[i].rpc;
            if_a.insn_ready_i  = vq[i].rdy;
            @(negedge clk);
            check($sformatf("A[%0d] mem_read_en", i), {31'd0, if_a.mem_read_en_o}, {31'd0, vq[i].exp_en});
            if (vq[i].exp_en)
                check($sformatf("A[%0d] mem_addr", i), if_a.mem_addr_o, vq[i].exp_addr);
            check($sformatf("A[%0d] insn_valid", i), {31'd0, if_a.insn_valid_o}, {31'd0, vq[i].exp_vld});
            if (!vq[i].redir) begin
                check($sformatf("A[%0d] pc", i), if_a.pc_o, vq[i].exp_vld ? vq[i].exp_pc : 32'h0);
                check($sformatf("A[%0d] insn", i), if_a.insn_o,
                      vq[i].exp_vld ? insn_of(vq[i].exp_pc) : 32'h0);
            end
            @(posedge clk); #1;
        end
        if_a.redirect_i = 1'b0;

        // ---- B: redirect to 0x203 with 3 queued and 2 in flight ----
        rst_b = 1'b1;
        if_b.insn_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("B issue%0d en", k), {31'd0, if_b.mem_read_en_o}, 32'd1);
            check($sformatf("B issue%0d addr", k), if_b.mem_addr_o, B + 32'(4 * k));
            if (k == 4) check("B head pc before redirect", if_b.pc_o, B);
            @(posedge clk); #1;
        end
        if_b.redirect_i = 1'b1;
        if_b.redirect_pc_i = 32'h0000_0203;
        @(negedge clk);
        check("B redirect en", {31'd0, if_b.mem_read_en_o}, 32'd0);
        check("B redirect valid", {31'd0, if_b.insn_valid_o}, 32'd0);
        @(posedge clk); #1;
        if_b.redirect_i = 1'b0;
        if_b.insn_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("B post%0d en", k), {31'd0, if_b.mem_read_en_o}, 32'd1);
            check($sformatf("B post%0d addr", k), if_b.mem_addr_o, 32'h0000_0200 + 32'(4 * k));
            check($sformatf("B post%0d valid", k), {31'd0, if_b.insn_valid_o}, (k >= 3) ? 32'd1 : 32'd0);
            if (k >= 3) begin
                check($sformatf("B post%0d pc", k), if_b.pc_o, 32'h0000_0200 + 32'(4 * (k - 3)));
                check($sformatf("B post%0d insn", k), if_b.insn_o, insn_of(32'h0000_0200 + 32'(4 * (k - 3))));
            end
`ifdef FETCH_PERF_EN
            if (k == 0) begin
                check("B perf_flush", pf_b, 32'd5);
                check("B perf_issue", pi_b, 32'd5);
                check("B perf_stall", ps_b, 32'd0);
            end
`endif
            @(posedge clk); #1;
        end

        // ---- C: MEM_LAT=3, reset with 3 requests in flight ----
        rst_c = 1'b1;
        if_c.insn_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("C issue%0d addr", k), if_c.mem_addr_o, B + 32'(4 * k));
            @(posedge clk); #1;
        end
        rst_c = 1'b0;
        @(negedge clk);
        check("C reset en", {31'd0, if_c.mem_read_en_o}, 32'd0);
        check("C reset valid", {31'd0, if_c.insn_valid_o}, 32'd0);
        @(posedge clk); #1;
        rst_c = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) check("C restart addr", if_c.mem_addr_o, B);
            check($sformatf("C after%0d valid", k), {31'd0, if_c.insn_valid_o}, (k >= 4) ? 32'd1 : 32'd0);
            if (k >= 4) check($sformatf("C after%0d pc", k), if_c.pc_o, B + 32'(4 * (k - 4)));
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
